clk_step_ctrl: RTL and testbench
================================

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20_000: consecutive identical synchronized button samples required before a level change is accepted.
REQ-002 Parameter COUNT_W, default 8: width of step_count.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 slow_clk  input  1  divided clock from the clock divider, synchronous to clk; its rising edge is the CPU advance tick.
REQ-006 btn_run  input  1  raw, asynchronous run/halt toggle button, active-high.
REQ-007 btn_step  input  1  raw, asynchronous single-step button, active-high.
REQ-008 halt_req  input  1  synchronous halt request from the CPU (e.g. HLT instruction), active-high level.
REQ-009 cpu_en  output  1  one-clk-wide clock-enable pulse that advances the CPU by one instruction.
REQ-010 running  output  1  high while in state RUN.
REQ-011 step_count  output  COUNT_W  number of cpu_en pulses issued, modulo 2^COUNT_W.

Function
REQ-012 slow_clk shall be registered once (slow_q); tick = slow_clk & ~slow_q; a falling edge shall never produce a tick.
REQ-013 Each button shall pass through a 2-flop synchronizer before any other use.
REQ-014 Each synchronized button shall feed a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive samples differ from it; any sample equal to the current level clears the counter.
REQ-015 Debounce counter width shall be $clog2(DEBOUNCE_CYCLES+1); the counter shall saturate and never wrap.
REQ-016 A press event is a 0->1 transition of the debounced level and lasts exactly one clk; releases generate no event.
REQ-017 The FSM shall have states HALT, RUN, and STEP_WAIT.
REQ-018 HALT: run press -> RUN; else step press -> STEP_WAIT; halt_req is ignored.
REQ-019 RUN: halt_req or run press -> HALT with no pulse; else, on a tick, cpu_en is asserted.
REQ-020 STEP_WAIT: halt_req -> HALT with no pulse; else, on a tick, cpu_en is asserted and the FSM goes to HALT; step and run presses are ignored.
REQ-021 Priority in every state: halt_req > run press > step press > tick.
REQ-022 cpu_en shall be registered: a tick in cycle N yields cpu_en=1 in cycle N+1 only; at most one pulse per slow_clk period.
REQ-023 step_count shall increment in the same cycle cpu_en is asserted and wrap from 2^COUNT_W-1 to 0.
REQ-024 running shall be registered and equal (state==RUN).
REQ-025 A step press arriving in RUN is discarded, not queued.

Reset
REQ-026 While rst_n=0, all of the following hold immediately regardless of clk:
  - state HALT
  - cpu_en 0, running 0, step_count 0
  - slow_q 0
  - synchronizers 0
  - debounced levels 0 and debounce counters 0
REQ-027 Reset asserted mid-STEP_WAIT or mid-RUN shall drop any pending pulse; after release the block waits in HALT.
REQ-028 A button held high through reset release shall produce a press event after the sync and debounce delay.

Verification (bench DEBOUNCE_CYCLES=4, COUNT_W=4, slow_clk period 8 clk)
REQ-029 Reset, then 5 slow_clk periods with no buttons pressed -> cpu_en stays 0, running=0, step_count=0.
REQ-030 Hold btn_run 10 clk -> running=1; the next 3 slow_clk rising edges each yield exactly one cpu_en pulse, 1 clk after the edge; step_count=3.
REQ-031 btn_step pressed for 2 clk (bounce) -> no event; held 10 clk -> exactly one cpu_en pulse at the next slow_clk rise, then state HALT and step_count +1.
REQ-032 In RUN, assert halt_req in the same cycle as a tick -> no cpu_en, running=0 next cycle.
REQ-033 In RUN for 17 ticks -> step_count wraps 15 -> 0 -> 1.
REQ-034 In STEP_WAIT, pulse rst_n low for 1 clk before the tick -> no cpu_en, state HALT, step_count=0.

Source files
------------

// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step controller: turns debounced front-panel buttons and the
// divided slow clock into one-clk cpu_en pulses that advance the CPU.
module clk_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20_000,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               slow_clk,
    input  logic               btn_run,
    input  logic               btn_step,
    input  logic               halt_req,
    output logic               cpu_en,
    output logic               running,
    output logic [COUNT_W-1:0] step_count
);

    localparam int                DBC_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBC_W-1:0]  DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT,
        S_RUN,
        S_STEP_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic               slow_q, slow_d;
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d;
    logic [DBC_W-1:0]   cnt_q [2];
    logic [DBC_W-1:0]   cnt_d [2];
    logic               cpu_en_q, cpu_en_d;
    logic               running_q, running_d;
    logic [COUNT_W-1:0] step_count_q, step_count_d;

    logic               tick;
    logic [1:0]         press;
    logic               run_press, step_press;

    // Bit 0 carries the run button, bit 1 the step button.
    always_comb begin
        slow_d  = slow_clk;
        tick    = slow_clk & ~slow_q;
        sync1_d = {btn_step, btn_run};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] >= DBC_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // A press is the single cycle in which the debounced level is about to rise.
        press      = deb_d & ~deb_q;
        run_press  = press[0];
        step_press = press[1];
    end

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        case (state_q)
            S_HALT: begin
                if (run_press) begin
                    state_d = S_RUN;
                end else if (step_press) begin
                    state_d = S_STEP_WAIT;
                end
            end
            S_RUN: begin
                if (halt_req || run_press) begin
                    state_d = S_HALT;
                end else if (tick) begin
                    cpu_en_d = 1'b1;
                end
            end
            S_STEP_WAIT: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (tick) begin
                    cpu_en_d = 1'b1;
                    state_d  = S_HALT;
                end
            end
            default: state_d = S_HALT;
        endcase
        running_d    = (state_d == S_RUN);
        step_count_d = step_count_q + COUNT_W'(cpu_en_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HALT;
            slow_q       <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            cpu_en_q     <= 1'b0;
            running_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            slow_q       <= slow_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            cpu_en_q     <= cpu_en_d;
            running_q    <= running_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign running    = running_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed and randomized bench for clk_step_ctrl, compared every cycle with a
// sample-history reference model of the buttons, slow clock and run/step modes.
module tb_clk_step_ctrl;

    localparam int DEB = 4;
    localparam int CW  = 4;
    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          slow_clk = 1'b0;
    logic          btn_run  = 1'b0;
    logic          btn_step = 1'b0;
    logic          halt_req = 1'b0;
    logic          cpu_en;
    logic          running;
    logic [CW-1:0] step_count;

    int n_chk = 0;
    int n_pass = 0;
    int sc = 4;
    int seg_pulses = 0;

    always #5 clk = ~clk;

    clk_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .COUNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .slow_clk   (slow_clk),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .halt_req   (halt_req),
        .cpu_en     (cpu_en),
        .running    (running),
        .step_count (step_count)
    );

    // Reference model: each button is seen two clocks late, its level flips once the
    // last DEB seen samples all disagree with it, and a rise of that level is a press.
    int m_mode = M_HALT;
    bit m_en = 1'b0;
    int m_cnt = 0;
    bit m_prev_slow = 1'b0;
    bit m_pipe [2][2];
    bit m_win  [2][DEB];
    bit m_lvl  [2];
    bit m_press[2];
    bit m_raw  [2];
    bit m_tick;
    bit m_samp;
    int m_ndiff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_HALT;
            m_en = 1'b0;
            m_cnt = 0;
            m_prev_slow = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_lvl[b] = 1'b0;
                m_press[b] = 1'b0;
                for (int j = 0; j < 2; j++) m_pipe[b][j] = 1'b0;
                for (int j = 0; j < DEB; j++) m_win[b][j] = 1'b0;
            end
        end else begin
            m_raw[0] = btn_run;
            m_raw[1] = btn_step;
            for (int b = 0; b < 2; b++) begin
                m_samp = m_pipe[b][0];
                m_pipe[b][0] = m_pipe[b][1];
                m_pipe[b][1] = m_raw[b];
                for (int j = 0; j < DEB - 1; j++) m_win[b][j] = m_win[b][j+1];
                m_win[b][DEB-1] = m_samp;
                m_ndiff = 0;
                for (int j = 0; j < DEB; j++) if (m_win[b][j] != m_lvl[b]) m_ndiff++;
                m_press[b] = 1'b0;
                if (m_ndiff == DEB) begin
                    m_press[b] = !m_lvl[b];
                    m_lvl[b] = !m_lvl[b];
                end
            end
            m_tick = slow_clk && !m_prev_slow;
            m_prev_slow = slow_clk;
            m_en = 1'b0;
            if (m_mode == M_HALT) begin
                if (m_press[0]) m_mode = M_RUN;
                else if (m_press[1]) m_mode = M_STEP;
            end else if (m_mode == M_RUN) begin
                if (halt_req || m_press[0]) m_mode = M_HALT;
                else if (m_tick) m_en = 1'b1;
            end else begin
                if (halt_req) m_mode = M_HALT;
                else if (m_tick) begin
                    m_en = 1'b1;
                    m_mode = M_HALT;
                end
            end
            if (m_en) m_cnt = (m_cnt + 1) % (1 << CW);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // One clock: check after the rising edge, then advance slow_clk on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
        chk("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
        chk("running", {31'd0, running}, {31'd0, (m_mode == M_RUN)});
        chk("step_count", {28'd0, step_count}, m_cnt);
        if (cpu_en === 1'b1) seg_pulses++;
        @(negedge clk);
        sc = (sc + 1) % 8;
        slow_clk = (sc < 4);
    endtask

    task automatic align(input int ph);
        for (int i = 0; i < 8 && sc != ph; i++) nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) nxt();
        chk("rst_cpu_en", {31'd0, cpu_en}, 0);
        chk("rst_running", {31'd0, running}, 0);
        chk("rst_step_count", {28'd0, step_count}, 0);
        rst_n = 1'b1;

        // Idle: five slow periods, nothing pressed
        seg_pulses = 0;
        repeat (40) nxt();
        chk("idle_pulses", seg_pulses, 0);
        chk("idle_running", {31'd0, running}, 0);
        chk("idle_count", {28'd0, step_count}, 0);

        // Run press, then three slow rising edges
        align(3);
        btn_run = 1'b1;
        repeat (10) nxt();
        btn_run = 1'b0;
        chk("run_running", {31'd0, running}, 1);
        seg_pulses = 0;
        repeat (24) nxt();
        chk("run_pulses", seg_pulses, 3);
        chk("run_count", {28'd0, step_count}, 3);

        // halt_req coincident with a tick
        align(0);
        halt_req = 1'b1;
        nxt();
        halt_req = 1'b0;
        chk("halt_cpu_en", {31'd0, cpu_en}, 0);
        chk("halt_running", {31'd0, running}, 0);
        repeat (8) nxt();
        chk("halt_count", {28'd0, step_count}, 3);

        // Bouncing step button, then a proper step
        seg_pulses = 0;
        btn_step = 1'b1;
        repeat (2) nxt();
        btn_step = 1'b0;
        repeat (10) nxt();
        chk("bounce_pulses", seg_pulses, 0);
        align(3);
        btn_step = 1'b1;
        repeat (10) nxt();
        btn_step = 1'b0;
        repeat (16) nxt();
        chk("step_pulses", seg_pulses, 1);
        chk("step_count", {28'd0, step_count}, 4);
        chk("step_running", {31'd0, running}, 0);

        // Asynchronous reset, then 17 ticks of RUN to wrap the counter
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", {28'd0, step_count}, 0);
        chk("async_rst_running", {31'd0, running}, 0);
        nxt();
        rst_n = 1'b1;
        align(3);
        btn_run = 1'b1;
        repeat (10) nxt();
        btn_run = 1'b0;
        seg_pulses = 0;
        repeat (132) nxt();
        chk("wrap_pulses", seg_pulses, 17);
        chk("wrap_count", {28'd0, step_count}, 1);
        btn_run = 1'b1;
        repeat (10) nxt();
        btn_run = 1'b0;
        repeat (8) nxt();
        chk("run_toggle_off", {31'd0, running}, 0);

        // Reset pulse while waiting for a step tick
        align(3);
        seg_pulses = 0;
        btn_step = 1'b1;
        repeat (10) nxt();
        btn_step = 1'b0;
        repeat (2) nxt();
        rst_n = 1'b0;
        #1;
        chk("sw_rst_cpu_en", {31'd0, cpu_en}, 0);
        chk("sw_rst_count", {28'd0, step_count}, 0);
        nxt();
        rst_n = 1'b1;
        repeat (9) nxt();
        chk("sw_rst_pulses", seg_pulses, 0);
        chk("sw_rst_count_after", {28'd0, step_count}, 0);
        chk("sw_rst_running", {31'd0, running}, 0);

        // Run button held through reset release
        btn_run = 1'b1;
        rst_n = 1'b0;
        repeat (2) nxt();
        rst_n = 1'b1;
        repeat (10) nxt();
        chk("held_through_rst", {31'd0, running}, 1);
        btn_run = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) btn_run = ~btn_run;
            if ($urandom_range(0, 11) == 0) btn_step = ~btn_step;
            halt_req = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 249) != 0);
            nxt();
        end
        rst_n = 1'b1;
        halt_req = 1'b0;
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
